// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions used by the fetch stage and its consumers.
package pipeline_pkg;

    // ResultSrc encoding that marks the execute-stage instruction as a load.
    localparam logic [1:0] RESULT_LOAD = 2'b01;

    // Encoding of "addi x0, x0, 0", the bubble inserted when the F/D register is cleared.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Fetch control states: one boot cycle after reset, then normal operation.
    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/hazard_unit.sv
// Load-use and control hazard detection with redirect-over-stall priority.
module hazard_unit
    import pipeline_pkg::*;
(
    input  logic       BootMode_i,
    input  logic       PCSrcE_i,
    input  logic [1:0] ResultSrcE_i,
    input  logic [4:0] RdE_i,
    input  logic [4:0] Rs1D_i,
    input  logic [4:0] Rs2D_i,
    output logic       Fen_o,
    output logic       Frst_o,
    output logic       FlushE_o,
    output logic       Redirect_o,
    output logic       Stall_o
);

    logic loadUse;

    // Classify the current cycle: boot kills everything, redirect beats load-use stall.
    always_comb begin
        Fen_o      = 1'b1;
        Frst_o     = 1'b0;
        FlushE_o   = 1'b0;
        Redirect_o = 1'b0;
        Stall_o    = 1'b0;
        loadUse    = (ResultSrcE_i == RESULT_LOAD) && (RdE_i != 5'd0) &&
                     ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));
        if (BootMode_i) begin
            Frst_o   = 1'b1;
            FlushE_o = 1'b1;
        end else if (PCSrcE_i) begin
            Frst_o     = 1'b1;
            FlushE_o   = 1'b1;
            Redirect_o = 1'b1;
        end else if (loadUse) begin
            Fen_o    = 1'b0;
            FlushE_o = 1'b1;
            Stall_o  = 1'b1;
        end
    end

endmodule

// File: rtl/fetch_top.sv
// Fetch-stage front end: PC register, boot FSM, hazard handling and event counters.
module fetch_top
    import pipeline_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  PCSrcE_i,
    input  logic [DATA_WIDTH-1:0] PCTargetE_i,
    input  logic [1:0]            ResultSrcE_i,
    input  logic [4:0]            RdE_i,
    input  logic [4:0]            Rs1D_i,
    input  logic [4:0]            Rs2D_i,
    output logic [DATA_WIDTH-1:0] PCF_o,
    output logic [DATA_WIDTH-1:0] PCPlus4F_o,
    output logic                  Fen_o,
    output logic                  Frst_o,
    output logic                  FlushE_o,
    output logic                  MisalignErr_o,
    output logic [31:0]           StallCnt_o,
    output logic [31:0]           FlushCnt_o
);

    fetch_state_t          state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic                  misalign_q, misalign_d;
    logic [31:0]           stallCnt_q, stallCnt_d;
    logic [31:0]           flushCnt_q, flushCnt_d;
    logic                  redirect;
    logic                  stall;

    hazard_unit u_hazard (
        .BootMode_i   (state_q == BOOT),
        .PCSrcE_i     (PCSrcE_i),
        .ResultSrcE_i (ResultSrcE_i),
        .RdE_i        (RdE_i),
        .Rs1D_i       (Rs1D_i),
        .Rs2D_i       (Rs2D_i),
        .Fen_o        (Fen_o),
        .Frst_o       (Frst_o),
        .FlushE_o     (FlushE_o),
        .Redirect_o   (redirect),
        .Stall_o      (stall)
    );

    // Next PC, FSM transition, sticky misalign flag and saturating counters.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = misalign_q;
        stallCnt_d = stallCnt_q;
        flushCnt_d = flushCnt_q;
        case (state_q)
            BOOT: begin
                state_d = RUN;
                pc_d    = RESET_PC;
            end
            RUN: begin
                if (redirect) begin
                    pc_d = {PCTargetE_i[DATA_WIDTH-1:2], 2'b00};
                    if (PCTargetE_i[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                    end
                    if (flushCnt_q != 32'hFFFF_FFFF) begin
                        flushCnt_d = flushCnt_q + 32'd1;
                    end
                end else if (stall) begin
                    if (stallCnt_q != 32'hFFFF_FFFF) begin
                        stallCnt_d = stallCnt_q + 32'd1;
                    end
                end else begin
                    pc_d = pc_q + DATA_WIDTH'(4);
                end
            end
            default: begin
                state_d = BOOT;
                pc_d    = RESET_PC;
            end
        endcase
    end

    // State registers; reset wins over any redirect or stall in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
            stallCnt_q <= 32'd0;
            flushCnt_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
            stallCnt_q <= stallCnt_d;
            flushCnt_q <= flushCnt_d;
        end
    end

    assign PCF_o         = pc_q;
    assign PCPlus4F_o    = pc_q + DATA_WIDTH'(4);
    assign MisalignErr_o = misalign_q;
    assign StallCnt_o    = stallCnt_q;
    assign FlushCnt_o    = flushCnt_q;

endmodule

// File: tb/tb_fetch_top.sv
// Directed self-checking bench for fetch_top with RESET_PC = 32'h100.
module tb_fetch_top;

    logic        clk;
    logic        rst;
    logic        PCSrcE_i;
    logic [31:0] PCTargetE_i;
    logic [1:0]  ResultSrcE_i;
    logic [4:0]  RdE_i;
    logic [4:0]  Rs1D_i;
    logic [4:0]  Rs2D_i;
    logic [31:0] PCF_o;
    logic [31:0] PCPlus4F_o;
    logic        Fen_o;
    logic        Frst_o;
    logic        FlushE_o;
    logic        MisalignErr_o;
    logic [31:0] StallCnt_o;
    logic [31:0] FlushCnt_o;

    int checkCount = 0;
    int passCount  = 0;

    fetch_top #(
        .DATA_WIDTH (32),
        .RESET_PC   (32'h100)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .PCSrcE_i      (PCSrcE_i),
        .PCTargetE_i   (PCTargetE_i),
        .ResultSrcE_i  (ResultSrcE_i),
        .RdE_i         (RdE_i),
        .Rs1D_i        (Rs1D_i),
        .Rs2D_i        (Rs2D_i),
        .PCF_o         (PCF_o),
        .PCPlus4F_o    (PCPlus4F_o),
        .Fen_o         (Fen_o),
        .Frst_o        (Frst_o),
        .FlushE_o      (FlushE_o),
        .MisalignErr_o (MisalignErr_o),
        .StallCnt_o    (StallCnt_o),
        .FlushCnt_o    (FlushCnt_o)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one edge and settle just past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive every hazard input to its quiet value.
    task automatic clearInputs();
        PCSrcE_i     = 1'b0;
        PCTargetE_i  = 32'h0;
        ResultSrcE_i = 2'b00;
        RdE_i        = 5'd0;
        Rs1D_i       = 5'd0;
        Rs2D_i       = 5'd0;
    endtask

    task automatic redirectTo(input logic [31:0] target);
        PCSrcE_i    = 1'b1;
        PCTargetE_i = target;
        step();
        clearInputs();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clearInputs();
        step();
        step();
        checkCount++; if (PCF_o !== 32'h100) $display("[TB] FAIL reset_pc got %h want %h", PCF_o, 32'h100); else passCount++;
        checkCount++; if (PCPlus4F_o !== 32'h104) $display("[TB] FAIL reset_pcplus4 got %h want %h", PCPlus4F_o, 32'h104); else passCount++;
        checkCount++; if ({Fen_o, Frst_o, FlushE_o} !== 3'b111) $display("[TB] FAIL reset_ctrl got %b want 111", {Fen_o, Frst_o, FlushE_o}); else passCount++;
        checkCount++; if (MisalignErr_o !== 1'b0) $display("[TB] FAIL reset_misalign got %b want 0", MisalignErr_o); else passCount++;
        checkCount++; if (StallCnt_o !== 32'd0 || FlushCnt_o !== 32'd0) $display("[TB] FAIL reset_counters got %0d/%0d want 0/0", StallCnt_o, FlushCnt_o); else passCount++;
        rst = 1'b0;
        #1;
        checkCount++; if (Frst_o !== 1'b1) $display("[TB] FAIL boot_frst got %b want 1", Frst_o); else passCount++;
        step();
        checkCount++; if (PCF_o !== 32'h100 || Frst_o !== 1'b0) $display("[TB] FAIL run_first got %h/%b want 100/0", PCF_o, Frst_o); else passCount++;
        step();
        checkCount++; if (PCF_o !== 32'h104) $display("[TB] FAIL run_second got %h want %h", PCF_o, 32'h104); else passCount++;
        step();
        checkCount++; if (PCF_o !== 32'h108) $display("[TB] FAIL run_third got %h want %h", PCF_o, 32'h108); else passCount++;
    endtask

    task automatic test_sequential();
        PCSrcE_i    = 1'b1;
        PCTargetE_i = 32'h0;
        #1;
        checkCount++; if ({Fen_o, Frst_o, FlushE_o} !== 3'b111) $display("[TB] FAIL redirect_ctrl got %b want 111", {Fen_o, Frst_o, FlushE_o}); else passCount++;
        step();
        clearInputs();
        checkCount++; if (FlushCnt_o !== 32'd1) $display("[TB] FAIL flushcnt_one got %0d want 1", FlushCnt_o); else passCount++;
        for (int i = 0; i < 5; i++) begin
            #1;
            checkCount++;
            if (PCF_o !== 32'(i * 4) || {Fen_o, Frst_o, FlushE_o} !== 3'b100)
                $display("[TB] FAIL seq_%0d got pc=%h ctrl=%b want pc=%h ctrl=100", i, PCF_o, {Fen_o, Frst_o, FlushE_o}, 32'(i * 4));
            else
                passCount++;
            step();
        end
    endtask

    task automatic test_load_use();
        redirectTo(32'h20);
        ResultSrcE_i = 2'b01;
        RdE_i        = 5'd5;
        Rs2D_i       = 5'd5;
        #1;
        checkCount++; if ({Fen_o, Frst_o, FlushE_o} !== 3'b001) $display("[TB] FAIL lu_ctrl got %b want 001", {Fen_o, Frst_o, FlushE_o}); else passCount++;
        step();
        clearInputs();
        checkCount++; if (PCF_o !== 32'h20 || StallCnt_o !== 32'd1) $display("[TB] FAIL lu_hold got %h/%0d want 20/1", PCF_o, StallCnt_o); else passCount++;
        #1;
        checkCount++; if (Fen_o !== 1'b1) $display("[TB] FAIL lu_release got %b want 1", Fen_o); else passCount++;
        step();
        checkCount++; if (PCF_o !== 32'h24) $display("[TB] FAIL lu_advance got %h want %h", PCF_o, 32'h24); else passCount++;
        ResultSrcE_i = 2'b01;
        RdE_i        = 5'd0;
        Rs1D_i       = 5'd0;
        #1;
        checkCount++; if (Fen_o !== 1'b1 || FlushE_o !== 1'b0) $display("[TB] FAIL lu_x0 got %b%b want 10", Fen_o, FlushE_o); else passCount++;
        step();
        clearInputs();
        checkCount++; if (PCF_o !== 32'h28 || StallCnt_o !== 32'd1) $display("[TB] FAIL lu_x0_pc got %h/%0d want 28/1", PCF_o, StallCnt_o); else passCount++;
    endtask

    task automatic test_priority();
        PCSrcE_i     = 1'b1;
        PCTargetE_i  = 32'h40;
        ResultSrcE_i = 2'b01;
        RdE_i        = 5'd5;
        Rs1D_i       = 5'd5;
        #1;
        checkCount++; if ({Fen_o, Frst_o, FlushE_o} !== 3'b111) $display("[TB] FAIL prio_ctrl got %b want 111", {Fen_o, Frst_o, FlushE_o}); else passCount++;
        step();
        clearInputs();
        checkCount++; if (PCF_o !== 32'h40) $display("[TB] FAIL prio_pc got %h want %h", PCF_o, 32'h40); else passCount++;
        checkCount++; if (FlushCnt_o !== 32'd3 || StallCnt_o !== 32'd1) $display("[TB] FAIL prio_counters got %0d/%0d want 3/1", FlushCnt_o, StallCnt_o); else passCount++;
    endtask

    task automatic test_misalign();
        checkCount++; if (MisalignErr_o !== 1'b0) $display("[TB] FAIL misalign_pre got %b want 0", MisalignErr_o); else passCount++;
        redirectTo(32'h43);
        checkCount++; if (PCF_o !== 32'h40 || MisalignErr_o !== 1'b1) $display("[TB] FAIL misalign_set got %h/%b want 40/1", PCF_o, MisalignErr_o); else passCount++;
        step();
        checkCount++; if (PCF_o !== 32'h44 || MisalignErr_o !== 1'b1) $display("[TB] FAIL misalign_sticky got %h/%b want 44/1", PCF_o, MisalignErr_o); else passCount++;
    endtask

    task automatic test_wrap();
        redirectTo(32'hFFFF_FFFC);
        checkCount++; if (PCF_o !== 32'hFFFF_FFFC || PCPlus4F_o !== 32'h0) $display("[TB] FAIL wrap_top got %h/%h want fffffffc/0", PCF_o, PCPlus4F_o); else passCount++;
        step();
        checkCount++; if (PCF_o !== 32'h0) $display("[TB] FAIL wrap_zero got %h want 0", PCF_o); else passCount++;
        checkCount++; if (FlushCnt_o !== 32'd5) $display("[TB] FAIL wrap_flushcnt got %0d want 5", FlushCnt_o); else passCount++;
    endtask

    task automatic test_reset_redirect();
        PCSrcE_i    = 1'b1;
        PCTargetE_i = 32'h80;
        rst         = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checkCount++; if (PCF_o !== 32'h100 || Frst_o !== 1'b1) $display("[TB] FAIL rst_over_rd got %h/%b want 100/1", PCF_o, Frst_o); else passCount++;
        checkCount++; if (MisalignErr_o !== 1'b0 || FlushCnt_o !== 32'd0 || StallCnt_o !== 32'd0) $display("[TB] FAIL rst_clear got %b/%0d/%0d want 0/0/0", MisalignErr_o, FlushCnt_o, StallCnt_o); else passCount++;
        PCTargetE_i  = 32'h200;
        ResultSrcE_i = 2'b01;
        RdE_i        = 5'd7;
        Rs1D_i       = 5'd7;
        step();
        clearInputs();
        checkCount++; if (PCF_o !== 32'h100 || FlushCnt_o !== 32'd0 || StallCnt_o !== 32'd0) $display("[TB] FAIL boot_ignore got %h/%0d/%0d want 100/0/0", PCF_o, FlushCnt_o, StallCnt_o); else passCount++;
        step();
        checkCount++; if (PCF_o !== 32'h104) $display("[TB] FAIL boot_resume got %h want %h", PCF_o, 32'h104); else passCount++;
    endtask

    // Run every scenario in order and report.
    initial begin
        rst = 1'b1;
        clearInputs();
        test_reset();
        test_sequential();
        test_load_use();
        test_priority();
        test_misalign();
        test_wrap();
        test_reset_redirect();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
